noc_traffic_node: RTL and testbench

Parametrised NoC endpoint for fabric simulation and on-FPGA bring-up: injects a configurable number of multi-flit packets toward one destination router and checks every packet it receives. It replaces the fixed three-flit single-channel test node: packet length, packet count, inter-packet gap and virtual-channel (VC) count are parameters, and payload is self-checking. It sits on the local port of one router, in place of a processing element.

---
 rtl/noc_traffic_node.sv | 336 +++++++++++++++++++++++++++++++++
 tb/tb_noc_traffic_node.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_traffic_node.sv
// NoC traffic endpoint: injects NUM_PKTS self-describing packets toward one router
// and checks header/payload/tail of every packet received on the local port.

`ifndef Noc_Data_Width
`define Noc_Data_Width 64
`endif
`ifndef Noc_ID_X_Width
`define Noc_ID_X_Width 2
`endif
`ifndef Noc_ID_Y_Width
`define Noc_ID_Y_Width 2
`endif
`ifndef Axi_PACK_ORDER_Bit
`define Axi_PACK_ORDER_Bit 16
`endif
`ifndef Noc_Head_H
`define Noc_Head_H 4'hA
`endif
`ifndef Noc_Head_E
`define Noc_Head_E 4'h5
`endif
`ifndef Noc_Tail_H
`define Noc_Tail_H 4'hC
`endif
`ifndef Noc_Tail_E
`define Noc_Tail_E 4'h3
`endif

module noc_traffic_node #(
  parameter logic [`Noc_ID_X_Width-1:0] X_ID      = {`Noc_ID_X_Width{1'b0}},
  parameter logic [`Noc_ID_Y_Width-1:0] Y_ID      = {`Noc_ID_Y_Width{1'b0}},
  parameter logic [`Noc_ID_X_Width-1:0] DEST_X_ID = {`Noc_ID_X_Width{1'b0}},
  parameter logic [`Noc_ID_Y_Width-1:0] DEST_Y_ID = {`Noc_ID_Y_Width{1'b0}},
  parameter int NUM_VC   = 2,
  parameter int PKT_LEN  = 4,
  parameter int NUM_PKTS = 8,
  parameter int GAP      = 0
) (
  input  logic                       noc_clk,
  input  logic                       noc_rst_n,
  input  logic                       send_start,
  input  logic                       rx_hold,
  input  logic [NUM_VC-1:0]          receive_valid,
  output logic [NUM_VC-1:0]          receive_ready,
  input  logic [`Noc_Data_Width-1:0] receive_flit,
  input  logic                       receive_is_header,
  input  logic                       receive_is_tail,
  output logic [NUM_VC-1:0]          sender_valid,
  input  logic [NUM_VC-1:0]          sender_ready,
  output logic [`Noc_Data_Width-1:0] sender_flit,
  output logic                       sender_is_header,
  output logic                       sender_is_tail,
  output logic                       tx_busy,
  output logic                       tx_done,
  output logic [15:0]                rx_pkt_cnt,
  output logic                       rx_err,
  output logic [15:0]                rx_err_cnt
);

  localparam int DW       = `Noc_Data_Width;
  localparam int XW       = `Noc_ID_X_Width;
  localparam int YW       = `Noc_ID_Y_Width;
  localparam int POW      = `Axi_PACK_ORDER_Bit;
  localparam int VCW      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int HDR_BITS = 4 + 2 * XW + 2 * YW + 2 + POW + 8 + 4;
  localparam int TL_BITS  = 4 + 2 * XW + 2 * YW;
  // Bit positions of the header fields the receiver inspects
  localparam int P_DX     = DW - 5 - XW - YW;
  localparam int P_DY     = P_DX - XW;
  localparam int P_PO     = P_DY - YW - 2;
  localparam int P_HE     = P_PO - POW - 8;

  localparam logic [7:0]     PLEN8    = PKT_LEN[7:0];
  localparam logic [15:0]    LAST_SEQ = 16'(NUM_PKTS - 1);
  localparam logic [7:0]     GAP_LAST = 8'(GAP - 1);
  localparam logic [VCW-1:0] VC_LAST  = VCW'(NUM_VC - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_TAIL = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

  localparam logic [1:0] RX_HDR  = 2'd0;
  localparam logic [1:0] RX_DATA = 2'd1;
  localparam logic [1:0] RX_TAIL = 2'd2;

  function automatic logic [DW-1:0] make_header(input logic [15:0] seq);
    logic [DW-1:0] f;
    f = {DW{1'b0}};
    f[DW-1 -: HDR_BITS] = {`Noc_Head_H, X_ID, Y_ID, DEST_X_ID, DEST_Y_ID, 2'b00,
                           seq[POW-1:0], PLEN8, `Noc_Head_E};
    return f;
  endfunction

  function automatic logic [DW-1:0] make_tail();
    logic [DW-1:0] f;
    f = {DW{1'b0}};
    f[DW-1 -: TL_BITS] = {`Noc_Tail_H, X_ID, Y_ID, DEST_X_ID, DEST_Y_ID};
    f[3:0] = `Noc_Tail_E;
    return f;
  endfunction

  function automatic logic [DW-1:0] make_data(input logic [15:0] seq, input logic [7:0] idx);
    logic [DW-1:0] f;
    f = {DW{1'b0}};
    f[23:0] = {seq, idx};
    return f;
  endfunction

  function automatic logic [NUM_VC-1:0] vc_onehot(input logic [VCW-1:0] vc);
    logic [NUM_VC-1:0] oh;
    for (int v = 0; v < NUM_VC; v++) begin
      oh[v] = (vc == VCW'(v));
    end
    return oh;
  endfunction

  function automatic logic [VCW-1:0] next_vc(input logic [VCW-1:0] vc);
    return (vc == VC_LAST) ? {VCW{1'b0}} : vc + {{(VCW-1){1'b0}}, 1'b1};
  endfunction

  logic [2:0]     tx_state_r;
  logic [15:0]    tx_seq_r;
  logic [7:0]     tx_idx_r;
  logic [7:0]     gap_cnt_r;
  logic [VCW-1:0] tx_vc_r;
  logic           tx_fire_s;

  assign tx_fire_s = |(sender_valid & sender_ready);

  // TX sequencer: every sender output is a register loaded one step ahead
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      tx_state_r       <= ST_IDLE;
      tx_seq_r         <= 16'd0;
      tx_idx_r         <= 8'd0;
      gap_cnt_r        <= 8'd0;
      tx_vc_r          <= {VCW{1'b0}};
      sender_valid     <= {NUM_VC{1'b0}};
      sender_flit      <= {DW{1'b0}};
      sender_is_header <= 1'b0;
      sender_is_tail   <= 1'b0;
      tx_busy          <= 1'b0;
      tx_done          <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (tx_state_r)
        ST_IDLE: begin
          if (send_start) begin
            tx_seq_r         <= 16'd0;
            tx_vc_r          <= {VCW{1'b0}};
            sender_valid     <= vc_onehot({VCW{1'b0}});
            sender_flit      <= make_header(16'd0);
            sender_is_header <= 1'b1;
            tx_busy          <= 1'b1;
            tx_state_r       <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (tx_fire_s) begin
            sender_flit      <= make_data(tx_seq_r, 8'd1);
            sender_is_header <= 1'b0;
            tx_idx_r         <= 8'd1;
            tx_state_r       <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tx_fire_s) begin
            if (tx_idx_r == PLEN8) begin
              sender_flit    <= make_tail();
              sender_is_tail <= 1'b1;
              tx_state_r     <= ST_TAIL;
            end else begin
              tx_idx_r    <= tx_idx_r + 8'd1;
              sender_flit <= make_data(tx_seq_r, tx_idx_r + 8'd1);
            end
          end
        end
        ST_TAIL: begin
          if (tx_fire_s) begin
            sender_is_tail <= 1'b0;
            if (tx_seq_r == LAST_SEQ) begin
              sender_valid <= {NUM_VC{1'b0}};
              sender_flit  <= {DW{1'b0}};
              tx_busy      <= 1'b0;
              tx_done      <= 1'b1;
              tx_state_r   <= ST_IDLE;
            end else begin
              tx_seq_r <= tx_seq_r + 16'd1;
              tx_vc_r  <= next_vc(tx_vc_r);
              if (GAP == 0) begin
                sender_valid     <= vc_onehot(next_vc(tx_vc_r));
                sender_flit      <= make_header(tx_seq_r + 16'd1);
                sender_is_header <= 1'b1;
                tx_state_r       <= ST_HDR;
              end else begin
                sender_valid <= {NUM_VC{1'b0}};
                sender_flit  <= {DW{1'b0}};
                gap_cnt_r    <= 8'd0;
                tx_state_r   <= ST_GAP;
              end
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            sender_valid     <= vc_onehot(tx_vc_r);
            sender_flit      <= make_header(tx_seq_r);
            sender_is_header <= 1'b1;
            tx_state_r       <= ST_HDR;
          end else begin
            gap_cnt_r <= gap_cnt_r + 8'd1;
          end
        end
        default: tx_state_r <= ST_IDLE;
      endcase
    end
  end

  logic [1:0]     rx_state_r [NUM_VC];
  logic [7:0]     rx_idx_r   [NUM_VC];
  logic [15:0]    rx_seq_r   [NUM_VC];
  logic [VCW-1:0] rx_vc_s;
  logic [3:0]     rx_vcnt_s;
  logic           rx_fire_s, rx_bad_s, hdr_ok_s, data_mark_s, tail_ok_s;
  logic [1:0]     cur_state_s, nxt_state_s;
  logic [7:0]     cur_idx_s, nxt_idx_s;
  logic [15:0]    cur_seq_s, nxt_seq_s, rx_po_s;
  logic [DW-1:0]  exp_data_s;
  logic           err_s, pkt_s, rx_err_ev_s, rx_pkt_ev_s;

  // RX checker: decode the VC, classify the flit and compute the next per-VC state
  always_comb begin
    rx_vc_s   = {VCW{1'b0}};
    rx_vcnt_s = 4'd0;
    for (int v = 0; v < NUM_VC; v++) begin
      rx_vc_s   = receive_valid[v] ? VCW'(v) : rx_vc_s;
      rx_vcnt_s = rx_vcnt_s + {3'b000, receive_valid[v]};
    end
    rx_fire_s   = (rx_vcnt_s == 4'd1) && (|(receive_valid & receive_ready));
    rx_bad_s    = (rx_vcnt_s != 4'd1) && (|(receive_valid & receive_ready));
    rx_po_s     = 16'(receive_flit[P_PO -: POW]);
    hdr_ok_s    = receive_is_header && !receive_is_tail &&
                  (receive_flit[DW-1 -: 4] == `Noc_Head_H) &&
                  (receive_flit[P_HE -: 4] == `Noc_Head_E) &&
                  (receive_flit[P_DX -: XW] == X_ID) && (receive_flit[P_DY -: YW] == Y_ID);
    data_mark_s = !receive_is_header && !receive_is_tail;
    tail_ok_s   = receive_is_tail && !receive_is_header &&
                  (receive_flit[DW-1 -: 4] == `Noc_Tail_H) && (receive_flit[3:0] == `Noc_Tail_E);
    cur_state_s = rx_state_r[rx_vc_s];
    cur_idx_s   = rx_idx_r[rx_vc_s];
    cur_seq_s   = rx_seq_r[rx_vc_s];
    exp_data_s  = make_data(cur_seq_s, cur_idx_s);
    nxt_state_s = cur_state_s;
    nxt_idx_s   = cur_idx_s;
    nxt_seq_s   = cur_seq_s;
    err_s       = 1'b0;
    pkt_s       = 1'b0;
    case (cur_state_s)
      RX_HDR: begin
        if (hdr_ok_s) begin
          nxt_state_s = RX_DATA;
          nxt_idx_s   = 8'd1;
          nxt_seq_s   = rx_po_s;
        end else begin
          err_s = 1'b1;
        end
      end
      RX_DATA: begin
        if (data_mark_s) begin
          err_s       = (receive_flit != exp_data_s);
          nxt_idx_s   = cur_idx_s + 8'd1;
          nxt_state_s = (cur_idx_s == PLEN8) ? RX_TAIL : RX_DATA;
        end else if (hdr_ok_s) begin
          err_s       = 1'b1;
          nxt_state_s = RX_DATA;
          nxt_idx_s   = 8'd1;
          nxt_seq_s   = rx_po_s;
        end else begin
          err_s       = 1'b1;
          nxt_state_s = RX_HDR;
        end
      end
      RX_TAIL: begin
        if (tail_ok_s) begin
          pkt_s       = 1'b1;
          nxt_state_s = RX_HDR;
        end else if (hdr_ok_s) begin
          err_s       = 1'b1;
          nxt_state_s = RX_DATA;
          nxt_idx_s   = 8'd1;
          nxt_seq_s   = rx_po_s;
        end else begin
          err_s       = 1'b1;
          nxt_state_s = RX_HDR;
        end
      end
      default: nxt_state_s = RX_HDR;
    endcase
    rx_err_ev_s = (rx_fire_s && err_s) || rx_bad_s;
    rx_pkt_ev_s = rx_fire_s && pkt_s;
  end

  // RX state, ready and counters
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      for (int v = 0; v < NUM_VC; v++) begin
        rx_state_r[v] <= RX_HDR;
        rx_idx_r[v]   <= 8'd0;
        rx_seq_r[v]   <= 16'd0;
      end
      receive_ready <= {NUM_VC{1'b0}};
      rx_pkt_cnt    <= 16'd0;
      rx_err        <= 1'b0;
      rx_err_cnt    <= 16'd0;
    end else begin
      receive_ready <= {NUM_VC{~rx_hold}};
      if (rx_fire_s) begin
        rx_state_r[rx_vc_s] <= nxt_state_s;
        rx_idx_r[rx_vc_s]   <= nxt_idx_s;
        rx_seq_r[rx_vc_s]   <= nxt_seq_s;
      end
      if (rx_pkt_ev_s) begin
        rx_pkt_cnt <= rx_pkt_cnt + 16'd1;
      end
      if (rx_err_ev_s) begin
        rx_err <= 1'b1;
        if (rx_err_cnt != 16'hFFFF) begin
          rx_err_cnt <= rx_err_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_noc_traffic_node.sv
// Scoreboard bench for noc_traffic_node: loopback runs, a stalled run with gaps,
// and directed receive-side packets with corrupted and malformed flits.

module tb_noc_traffic_node;

  typedef struct packed {
    logic [63:0] flit;
    logic        h;
    logic        t;
    logic [1:0]  vc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance: GAP=0, loopback or bench-driven receive side
  logic        rst_n = 1'b0, start = 1'b0, hold = 1'b0, lb = 1'b0;
  logic [1:0]  rv, rr, sv, sr, drv_valid = 2'b00;
  logic [63:0] rflit, sflit, drv_flit = 64'd0;
  logic        rh, rt, sh, st, drv_h = 1'b0, drv_t = 1'b0;
  logic        busy, done, rerr;
  logic [15:0] pkt_cnt, err_cnt;

  assign rv    = lb ? sv : drv_valid;
  assign rflit = lb ? sflit : drv_flit;
  assign rh    = lb ? sh : drv_h;
  assign rt    = lb ? st : drv_t;
  assign sr    = lb ? rr : 2'b11;

  noc_traffic_node #(.X_ID(2'd1), .Y_ID(2'd2), .DEST_X_ID(2'd1), .DEST_Y_ID(2'd2),
                     .NUM_VC(2), .PKT_LEN(4), .NUM_PKTS(8), .GAP(0)) u_dut (
    .noc_clk(clk), .noc_rst_n(rst_n), .send_start(start), .rx_hold(hold),
    .receive_valid(rv), .receive_ready(rr), .receive_flit(rflit),
    .receive_is_header(rh), .receive_is_tail(rt),
    .sender_valid(sv), .sender_ready(sr), .sender_flit(sflit),
    .sender_is_header(sh), .sender_is_tail(st),
    .tx_busy(busy), .tx_done(done), .rx_pkt_cnt(pkt_cnt), .rx_err(rerr), .rx_err_cnt(err_cnt));

  // gap instance: GAP=3, random ready on a loopback
  logic        g_rst_n = 1'b0, g_start = 1'b0, g_mask = 1'b0;
  logic [1:0]  g_rv, g_rr, g_sv, g_sr;
  logic [63:0] g_sflit;
  logic        g_sh, g_st, g_busy, g_done, g_rerr;
  logic [15:0] g_pkt_cnt, g_err_cnt;

  assign g_rv = g_sv & {2{g_mask}};
  assign g_sr = g_rr & {2{g_mask}};

  noc_traffic_node #(.X_ID(2'd1), .Y_ID(2'd2), .DEST_X_ID(2'd1), .DEST_Y_ID(2'd2),
                     .NUM_VC(2), .PKT_LEN(3), .NUM_PKTS(6), .GAP(3)) u_gap (
    .noc_clk(clk), .noc_rst_n(g_rst_n), .send_start(g_start), .rx_hold(1'b0),
    .receive_valid(g_rv), .receive_ready(g_rr), .receive_flit(g_sflit),
    .receive_is_header(g_sh), .receive_is_tail(g_st),
    .sender_valid(g_sv), .sender_ready(g_sr), .sender_flit(g_sflit),
    .sender_is_header(g_sh), .sender_is_tail(g_st),
    .tx_busy(g_busy), .tx_done(g_done), .rx_pkt_cnt(g_pkt_cnt), .rx_err(g_rerr), .rx_err_cnt(g_err_cnt));

  function automatic logic [63:0] bhdr(input logic [15:0] seq, input logic [7:0] len);
    return {4'hA, 2'd1, 2'd2, 2'd1, 2'd2, 2'b00, seq, len, 4'h5, 22'd0};
  endfunction

  function automatic logic [63:0] btail();
    return {4'hC, 2'd1, 2'd2, 2'd1, 2'd2, 48'd0, 4'h3};
  endfunction

  function automatic logic [63:0] bdata(input logic [15:0] seq, input logic [7:0] i);
    return {40'd0, seq, i};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  exp_t m_q[$];
  exp_t g_q[$];

  task automatic push_run(input bit to_gap, input int len, input int npk);
    exp_t e;
    for (int n = 0; n < npk; n++) begin
      e.vc = (n % 2 == 0) ? 2'b01 : 2'b10;
      e.flit = bhdr(16'(n), 8'(len)); e.h = 1'b1; e.t = 1'b0;
      if (to_gap) g_q.push_back(e); else m_q.push_back(e);
      for (int i = 1; i <= len; i++) begin
        e.flit = bdata(16'(n), 8'(i)); e.h = 1'b0; e.t = 1'b0;
        if (to_gap) g_q.push_back(e); else m_q.push_back(e);
      end
      e.flit = btail(); e.h = 1'b0; e.t = 1'b1;
      if (to_gap) g_q.push_back(e); else m_q.push_back(e);
    end
  endtask

  // main TX monitor
  exp_t       m_e;
  logic [1:0] m_fire;
  int m_nfire = 0, m_first = -1, m_last = -1, m_done = -1;
  always @(negedge clk) begin
    #1;
    m_fire = sv & sr;
    if (m_fire != 2'b00) begin
      if (m_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL tx_unexpected actual=%0h required=none", sflit);
      end else begin
        m_e = m_q.pop_front();
        chk("tx_flit", sflit, m_e.flit);
        chk("tx_hdr", {63'd0, sh}, {63'd0, m_e.h});
        chk("tx_tail", {63'd0, st}, {63'd0, m_e.t});
        chk("tx_vc", {62'd0, m_fire}, {62'd0, m_e.vc});
      end
      m_nfire++;
      if (m_first < 0) m_first = cyc;
      m_last = cyc;
    end
    if (done) m_done = cyc;
  end

  // gap-instance monitor: randomises ready, checks stability, order and gap length
  exp_t        g_e;
  logic [1:0]  g_fire, g_prev_vc;
  logic [63:0] g_prev_flit;
  bit g_stalled = 1'b0, g_after_tail = 1'b0, g_done_seen = 1'b0;
  int g_idle = 0;
  always @(negedge clk) begin
    g_mask = 1'($urandom_range(0, 1));
    #1;
    if (g_rst_n) begin
      g_fire = g_sv & g_sr;
      if (g_stalled) begin
        chk("gap_stable_flit", g_sflit, g_prev_flit);
        chk("gap_stable_vc", {62'd0, g_sv}, {62'd0, g_prev_vc});
      end
      if (g_fire != 2'b00) begin
        if (g_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL gap_unexpected actual=%0h required=none", g_sflit);
        end else begin
          g_e = g_q.pop_front();
          chk("gap_flit", g_sflit, g_e.flit);
          chk("gap_vc", {62'd0, g_fire}, {62'd0, g_e.vc});
        end
        if (g_sh && g_after_tail) begin
          chk("gap_idle_ge3", {63'd0, g_idle >= 3}, 64'd1);
          g_after_tail = 1'b0;
        end
        if (g_st) begin
          g_after_tail = 1'b1;
          g_idle = 0;
        end
      end else if (g_sv == 2'b00 && g_after_tail) begin
        g_idle++;
      end
      g_stalled   = (g_sv != 2'b00) && (g_fire == 2'b00);
      g_prev_flit = g_sflit;
      g_prev_vc   = g_sv;
      if (g_done) g_done_seen = 1'b1;
    end
  end

  task automatic rx_flit(input logic [1:0] v, input logic [63:0] f, input logic h, input logic t);
    drv_valid = v; drv_flit = f; drv_h = h; drv_t = t;
    @(negedge clk);
    drv_valid = 2'b00; drv_h = 1'b0; drv_t = 1'b0;
  endtask

  task automatic rx_pkt(input logic [1:0] v, input logic [15:0] seq, input int bad_idx);
    logic [63:0] f;
    rx_flit(v, bhdr(seq, 8'd4), 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      f = bdata(seq, 8'(i));
      if (i == bad_idx) f = f ^ 64'h1;
      rx_flit(v, f, 1'b0, 1'b0);
    end
    rx_flit(v, btail(), 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_loopback(input string tag);
    int k;
    push_run(1'b0, 4, 8);
    m_nfire = 0; m_first = -1; m_last = -1; m_done = -1;
    start = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 300 && m_done < 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk({tag, "_first_cycle"}, 64'(m_first), 64'(k));
    chk({tag, "_transfers"}, 64'(m_nfire), 64'd48);
    chk({tag, "_consecutive"}, 64'(m_last - m_first), 64'd47);
    chk({tag, "_done_cycle"}, 64'(m_done - m_first + 1), 64'd49);
    chk({tag, "_busy_low"}, {63'd0, busy}, 64'd0);
    chk({tag, "_queue_empty"}, 64'(m_q.size()), 64'd0);
    chk({tag, "_rx_pkt_cnt"}, {48'd0, pkt_cnt}, 64'd8);
    chk({tag, "_rx_err_cnt"}, {48'd0, err_cnt}, 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_sender_valid", {62'd0, sv}, 64'd0);
    chk("rst_sender_flit", sflit, 64'd0);
    chk("rst_markers", {62'd0, sh, st}, 64'd0);
    chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
    chk("rst_receive_ready", {62'd0, rr}, 64'd0);
    chk("rst_rx_counts", {31'd0, rerr, pkt_cnt, err_cnt}, 64'd0);
    rst_n = 1'b1; g_rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // loopback runs on both instances together
    lb = 1'b1;
    push_run(1'b1, 3, 6);
    g_start = 1'b1;
    run_loopback("loop");
    g_start = 1'b0;

    // interleaved VC0/VC1 packets, after a backpressure check
    lb = 1'b0;
    do_reset();
    hold = 1'b1;
    repeat (2) @(negedge clk);
    chk("rx_hold_ready", {62'd0, rr}, 64'd0);
    hold = 1'b0;
    repeat (2) @(negedge clk);
    chk("rx_ready_back", {62'd0, rr}, 64'd3);
    rx_flit(2'b01, bhdr(16'd0, 8'd4), 1'b1, 1'b0);
    rx_flit(2'b10, bhdr(16'd1, 8'd4), 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      rx_flit(2'b01, bdata(16'd0, 8'(i)), 1'b0, 1'b0);
      rx_flit(2'b10, bdata(16'd1, 8'(i)), 1'b0, 1'b0);
    end
    rx_flit(2'b01, btail(), 1'b0, 1'b1);
    rx_flit(2'b10, btail(), 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("ilv_pkt_cnt", {48'd0, pkt_cnt}, 64'd2);
    chk("ilv_err_cnt", {48'd0, err_cnt}, 64'd0);

    // corrupted data flit 2 of seq 5
    do_reset();
    rx_pkt(2'b10, 16'd5, 2);
    repeat (2) @(negedge clk);
    chk("bad_err", {63'd0, rerr}, 64'd1);
    chk("bad_err_cnt", {48'd0, err_cnt}, 64'd1);
    chk("bad_pkt_cnt", {48'd0, pkt_cnt}, 64'd1);

    // data flit in EXP_HDR, then two VCs valid at once, then a good packet
    do_reset();
    rx_flit(2'b01, bdata(16'd0, 8'd1), 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("stray_err_cnt", {48'd0, err_cnt}, 64'd1);
    rx_flit(2'b11, bhdr(16'd3, 8'd4), 1'b1, 1'b0);
    rx_pkt(2'b01, 16'd3, 0);
    repeat (2) @(negedge clk);
    chk("multi_err_cnt", {48'd0, err_cnt}, 64'd2);
    chk("multi_pkt_cnt", {48'd0, pkt_cnt}, 64'd1);
    chk("multi_err_sticky", {63'd0, rerr}, 64'd1);

    // reset mid-packet, then a fresh run
    do_reset();
    lb = 1'b1;
    push_run(1'b0, 4, 8);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {62'd0, sv}, 64'd0);
    chk("mid_rst_flit", sflit, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_ready", {62'd0, rr}, 64'd0);
    chk("mid_rst_cnts", {31'd0, rerr, pkt_cnt, err_cnt}, 64'd0);
    m_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_loopback("rerun");

    // the stalled GAP=3 run finishes on its own
    for (int i = 0; i < 3000 && !g_done_seen; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("gap_done_seen", {63'd0, g_done_seen}, 64'd1);
    chk("gap_pkt_cnt", {48'd0, g_pkt_cnt}, 64'd6);
    chk("gap_err_cnt", {48'd0, g_err_cnt}, 64'd0);
    chk("gap_queue_empty", 64'(g_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
